// File: rtl/avalon_interval_timer_p_if.sv
`default_nettype none
// ============================================================
// avalon_interval_timer_p_if : Avalon-MM slave bus bundle for the interval timer
// Rev 1.0
// ============================================================
interface avalon_interval_timer_p_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  logic        timeout_pulse;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq, timeout_pulse
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq, timeout_pulse
  );
endinterface
`default_nettype wire

// File: rtl/avalon_interval_timer_p.sv
`default_nettype none
// ============================================================
// avalon_interval_timer_p : parametrised Avalon-MM interval timer with prescaler
// Rev 1.0
// ============================================================
module avalon_interval_timer_p #(
  parameter int COUNTER_WIDTH  = 32,
  parameter int RESET_PERIOD   = 99999,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  avalon_interval_timer_p_if.slave bus
);

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;
  localparam logic [2:0] ADDR_PRESCALE = 3'd6;

  localparam logic [COUNTER_WIDTH-1:0] RESET_VAL = COUNTER_WIDTH'(RESET_PERIOD);

  typedef enum logic [0:0] {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t state, state_next;

  logic [COUNTER_WIDTH-1:0]  counter;
  logic [COUNTER_WIDTH-1:0]  period;
  logic [COUNTER_WIDTH-1:0]  snapshot;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic [3:0]                control;
  logic                      to_flag;
  logic                      force_reload;
  logic                      pulse;
  logic [15:0]               rdata;
  logic [15:0]               rdata_next;

  logic wr;
  logic start_req;
  logic stop_req;
  logic running;
  logic tick;
  logic timeout_ev;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign start_req = wr && (bus.address == ADDR_CONTROL) && bus.writedata[2];
  assign stop_req  = wr && (bus.address == ADDR_CONTROL) && bus.writedata[3] && !bus.writedata[2];
  assign running   = (state == RUNNING);
  // A pending period reload suppresses the tick, so no timeout can fire in that cycle.
  assign tick       = running && (pre_cnt == '0) && !force_reload;
  assign timeout_ev = tick && (counter == '0);

  assign bus.readdata      = rdata;
  assign bus.timeout_pulse = pulse;
  assign bus.irq           = to_flag & control[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STOPPED;
    end else begin
      state <= state_next;
    end
  end

  // START has the highest priority; any stopping cause is otherwise honoured.
  always_comb begin
    state_next = state;
    case (state)
      STOPPED: begin
        if (start_req) state_next = RUNNING;
      end
      RUNNING: begin
        if (start_req) begin
          state_next = RUNNING;
        end else if (stop_req || force_reload || (timeout_ev && !control[1])) begin
          state_next = STOPPED;
        end
      end
      default: state_next = STOPPED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter      <= RESET_VAL;
      period       <= RESET_VAL;
      snapshot     <= '0;
      prescale     <= '0;
      pre_cnt      <= '0;
      control      <= '0;
      to_flag      <= 1'b0;
      force_reload <= 1'b0;
      pulse        <= 1'b0;
      rdata        <= '0;
    end else begin
      if (start_req || force_reload) begin
        pre_cnt <= '0;
      end else if (running) begin
        pre_cnt <= (pre_cnt == '0) ? prescale : pre_cnt - PRESCALE_WIDTH'(1);
      end

      if (force_reload) begin
        counter <= period;
      end else if (tick) begin
        counter <= (counter == '0) ? period : counter - COUNTER_WIDTH'(1);
      end

      force_reload <= wr && ((bus.address == ADDR_PERIOD_L) || (bus.address == ADDR_PERIOD_H));
      pulse        <= timeout_ev;

      if (timeout_ev) begin
        to_flag <= 1'b1;
      end else if (wr && (bus.address == ADDR_STATUS)) begin
        to_flag <= 1'b0;
      end

      if (wr) begin
        case (bus.address)
          ADDR_CONTROL:  control <= bus.writedata[3:0];
          ADDR_PERIOD_L: period[15:0] <= bus.writedata;
          ADDR_PERIOD_H: period[COUNTER_WIDTH-1:16] <= bus.writedata[COUNTER_WIDTH-17:0];
          ADDR_SNAP_L,
          ADDR_SNAP_H:   snapshot <= counter;
          ADDR_PRESCALE: prescale <= bus.writedata[PRESCALE_WIDTH-1:0];
          default: ;
        endcase
      end

      rdata <= rdata_next;
    end
  end

  logic [31:0] period_ext;
  logic [31:0] snap_ext;
  logic [15:0] pre_ext;

  always_comb begin
    period_ext                     = '0;
    period_ext[COUNTER_WIDTH-1:0]  = period;
    snap_ext                       = '0;
    snap_ext[COUNTER_WIDTH-1:0]    = snapshot;
    pre_ext                        = '0;
    pre_ext[PRESCALE_WIDTH-1:0]    = prescale;
    rdata_next                     = '0;
    case (bus.address)
      ADDR_STATUS:   rdata_next = {14'd0, running, to_flag};
      ADDR_CONTROL:  rdata_next = {12'd0, control};
      ADDR_PERIOD_L: rdata_next = period_ext[15:0];
      ADDR_PERIOD_H: rdata_next = period_ext[31:16];
      ADDR_SNAP_L:   rdata_next = snap_ext[15:0];
      ADDR_SNAP_H:   rdata_next = snap_ext[31:16];
      ADDR_PRESCALE: rdata_next = pre_ext;
      default:       rdata_next = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_interval_timer_p.sv
`default_nettype none
// ============================================================
// tb_avalon_interval_timer_p : directed and randomized checks of the interval timer
// Rev 1.0
// ============================================================
module tb_avalon_interval_timer_p;
  localparam int CW = 20;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   pulse_q[$];

  avalon_interval_timer_p_if bus ();

  avalon_interval_timer_p #(
    .COUNTER_WIDTH (CW),
    .RESET_PERIOD  (99999),
    .PRESCALE_WIDTH(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Record the cycle index of every observed pulse.
  always @(negedge clk) if (bus.timeout_pulse === 1'b1) pulse_q.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus.address = a;
    @(posedge clk);
    #1;
    d = bus.readdata;
  endtask

  task automatic rd_snap(output logic [31:0] v);
    logic [15:0] lo, hi;
    rd(3'd4, lo);
    rd(3'd5, hi);
    v = {hi, lo};
  endtask

  // Model: ticks land on run cycles S+1, S+1+(P+1), ...; the (C+1)-th tick is a timeout.
  task automatic run_case(input int c, input int p, input bit cont, input bit ito,
                          input int win, input int soff, input string tag);
    int S, t, T, pt, n, cnt_exp;
    int exp_q[$];
    bit exp_to;
    logic [15:0] d;
    logic [31:0] v;
    wr(3'd0, 16'h0);
    wr(3'd2, 16'(c));
    wr(3'd3, 16'(c >> 16));
    wr(3'd6, 16'(p));
    pulse_q.delete();
    S = cyc;
    wr(3'd1, 16'(4 + (cont ? 2 : 0) + (ito ? 1 : 0)));
    step(soff);
    t = cyc;
    wr(3'd4, 16'h0);
    step(win);
    T = cyc;
    pt = S + 2 + c * (p + 1);
    while (pt <= T + 1) begin
      exp_q.push_back(pt);
      if (!cont) break;
      pt += (c + 1) * (p + 1);
    end
    exp_to = (exp_q.size() > 0) && (exp_q[0] <= T);
    check({tag, "_irq"}, 32'(bus.irq), 32'(exp_to & ito));
    wr(3'd1, 16'h8);
    step(3);
    check({tag, "_npulse"}, pulse_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pulse_q.size(); i++)
      check($sformatf("%s_pulse%0d", tag, i), pulse_q[i], exp_q[i]);
    rd(3'd0, d);
    check({tag, "_status"}, d, {31'd0, exp_q.size() > 0});
    n = (t >= S + 2) ? (t - S - 2) / (p + 1) + 1 : 0;
    if (cont) cnt_exp = c - (n % (c + 1));
    else      cnt_exp = (n > c) ? c : c - n;
    rd_snap(v);
    check({tag, "_snap"}, v, cnt_exp);
  endtask

  initial begin
    logic [15:0] d;
    logic [31:0] v;
    int S, t, n;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 16'h0;
    reset          = 1'b1;
    step(2);
    check("rst_irq", 32'(bus.irq), 0);
    check("rst_pulse", 32'(bus.timeout_pulse), 0);
    check("rst_rdata", bus.readdata, 0);
    reset = 1'b0;
    rd(3'd0, d);  check("rst_status", d, 16'h0000);
    rd(3'd1, d);  check("rst_control", d, 16'h0000);
    rd(3'd6, d);  check("rst_prescale", d, 16'h0000);
    rd(3'd7, d);  check("rst_addr7", d, 16'h0000);
    wr(3'd4, 16'h0);
    rd(3'd4, d);  check("rst_snap_l", d, 16'h869F);
    rd(3'd5, d);  check("rst_snap_h", d, 16'h0001);

    run_case(3, 0, 1'b0, 1'b1, 50, 20, "oneshot");
    run_case(3, 1, 1'b1, 1'b0, 40, 5, "cont_pre");
    pulse_q.delete();
    step(30);
    check("stopped_no_pulse", pulse_q.size(), 0);
    run_case(0, 2, 1'b1, 1'b1, 20, 3, "period0");

    // Clear race: STATUS write in the exact timeout cycle keeps TO.
    wr(3'd0, 16'h0);
    wr(3'd2, 16'd3);
    wr(3'd3, 16'd0);
    wr(3'd6, 16'd0);
    S = cyc;
    wr(3'd1, 16'h7);
    step(3);
    check("race_cycle", cyc, S + 4);
    wr(3'd0, 16'h0);
    rd(3'd0, d);  check("race_to_kept", d, 16'h0003);
    step(3);
    check("race_irq_set", 32'(bus.irq), 1);
    wr(3'd0, 16'h0);
    check("race_irq_clear", 32'(bus.irq), 0);
    rd(3'd0, d);  check("race_to_cleared", d, 16'h0002);
    wr(3'd1, 16'h8);
    step(2);

    // Period write while counting at 0x10.
    wr(3'd0, 16'h0);
    wr(3'd2, 16'h20);
    wr(3'd3, 16'h0);
    wr(3'd6, 16'h0);
    pulse_q.delete();
    S = cyc;
    wr(3'd1, 16'h6);
    step(16);
    wr(3'd2, 16'h5);
    step(1);
    wr(3'd4, 16'h0);
    rd(3'd0, d);  check("preload_status", d, 16'h0000);
    rd_snap(v);   check("preload_counter", v, 5);
    step(20);
    check("preload_no_pulse", pulse_q.size(), 0);

    // Upper period bits beyond the counter width are dropped.
    wr(3'd3, 16'hFFFF);
    wr(3'd2, 16'h1234);
    rd(3'd3, d);  check("width_period_h", d, 16'h000F);
    rd(3'd2, d);  check("width_period_l", d, 16'h1234);
    wr(3'd6, 16'h0);
    S = cyc;
    wr(3'd1, 16'h6);
    step(10);
    t = cyc;
    wr(3'd4, 16'h0);
    n = (t - S - 2) + 1;
    rd_snap(v);   check("width_snap", v, 32'h000F_1234 - n);

    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_irq", 32'(bus.irq), 0);
    check("mid_rst_pulse", 32'(bus.timeout_pulse), 0);
    rd(3'd0, d);  check("mid_rst_status", d, 16'h0000);
    rd(3'd2, d);  check("mid_rst_period_l", d, 16'h869F);
    rd(3'd3, d);  check("mid_rst_period_h", d, 16'h0001);
    rd_snap(v);   check("mid_rst_snap", v, 0);
    wr(3'd4, 16'h0);
    rd_snap(v);   check("mid_rst_counter", v, 99999);

    for (int k = 0; k < 6; k++)
      run_case(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(20, 70)), int'($urandom_range(0, 25)),
               $sformatf("rand%0d", k));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
